register_file_rename: RTL and testbench

//  Architectural register file with rename tags; receives ROB commits and serves decoder operand reads.

---
 rtl/register_file_rename.sv | 114 +++++++++++
 tb/tb_register_file_rename.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_rename.sv
// Architectural register file with per-register rename tags. Decoder operands resolve from a
// same-cycle commit, the ROB lookup or the stored value; commits and renames update state.
module register_file_rename #(
   parameter int REG_WIDTH = 5,
   parameter int ROB_WIDTH = 4
) (
   input  logic                 clk_in,
   input  logic                 rst_n_in,
   input  logic                 rdy_in,
   input  logic                 flush,
   input  logic [REG_WIDTH-1:0] dec_rs1,
   input  logic [REG_WIDTH-1:0] dec_rs2,
   output logic                 dec_ready_j,
   output logic [31:0]          dec_val_j,
   output logic [ROB_WIDTH-1:0] dec_tag_j,
   output logic                 dec_ready_k,
   output logic [31:0]          dec_val_k,
   output logic [ROB_WIDTH-1:0] dec_tag_k,
   input  logic                 dec_rename_en,
   input  logic [REG_WIDTH-1:0] dec_rd,
   input  logic [ROB_WIDTH-1:0] dec_rob_id,
   output logic [ROB_WIDTH-1:0] rob_query_j,
   output logic [ROB_WIDTH-1:0] rob_query_k,
   input  logic                 rob_ready_j,
   input  logic                 rob_ready_k,
   input  logic [31:0]          rob_data_j,
   input  logic [31:0]          rob_data_k,
   input  logic [REG_WIDTH-1:0] commit_reg_id,
   input  logic [31:0]          commit_data,
   input  logic [ROB_WIDTH-1:0] commit_rob_id
);

   localparam int NREG = 2 ** REG_WIDTH;

   logic [31:0]          val_q  [NREG];
   logic [ROB_WIDTH-1:0] tag_q  [NREG];
   logic [NREG-1:0]      busy_q;

   logic [32:0] res_j;
   logic [32:0] res_k;
   logic        rename_ok;

   // Returns {ready, value}; x0 and idle registers never look at the ROB side.
   function automatic logic [32:0] resolve(
      input logic [REG_WIDTH-1:0] s,
      input logic                 busy,
      input logic [ROB_WIDTH-1:0] tag,
      input logic [31:0]          val,
      input logic                 rob_ready,
      input logic [31:0]          rob_data,
      input logic [REG_WIDTH-1:0] c_reg,
      input logic [ROB_WIDTH-1:0] c_rob,
      input logic [31:0]          c_data
   );
      logic [32:0] r;
      r = {1'b0, 32'd0};
      if (s == '0) begin
         r = {1'b1, 32'd0};
      end else if (!busy) begin
         r = {1'b1, val};
      end else if (c_reg == s && c_rob == tag) begin
         r = {1'b1, c_data};
      end else if (rob_ready) begin
         r = {1'b1, rob_data};
      end
      return r;
   endfunction

   always_comb begin
      res_j = resolve(dec_rs1, busy_q[dec_rs1], tag_q[dec_rs1], val_q[dec_rs1],
                      rob_ready_j, rob_data_j, commit_reg_id, commit_rob_id, commit_data);
      res_k = resolve(dec_rs2, busy_q[dec_rs2], tag_q[dec_rs2], val_q[dec_rs2],
                      rob_ready_k, rob_data_k, commit_reg_id, commit_rob_id, commit_data);
   end

   assign dec_ready_j = res_j[32];
   assign dec_val_j   = res_j[31:0];
   assign dec_ready_k = res_k[32];
   assign dec_val_k   = res_k[31:0];
   assign dec_tag_j   = tag_q[dec_rs1];
   assign dec_tag_k   = tag_q[dec_rs2];
   assign rob_query_j = tag_q[dec_rs1];
   assign rob_query_k = tag_q[dec_rs2];

   assign rename_ok = dec_rename_en && (dec_rd != '0) && !flush;

   // Entry 0 is never written, so x0 keeps its reset value of zero forever.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         for (int r = 0; r < NREG; r++) begin
            val_q[r] <= '0;
            tag_q[r] <= '0;
         end
         busy_q <= '0;
      end else if (rdy_in) begin
         for (int r = 1; r < NREG; r++) begin
            if (commit_reg_id == REG_WIDTH'(r)) begin
               val_q[r] <= commit_data;
            end
            // Flush beats everything; a rename beats the busy clear of a same-cycle commit.
            if (flush) begin
               busy_q[r] <= 1'b0;
            end else if (rename_ok && dec_rd == REG_WIDTH'(r)) begin
               busy_q[r] <= 1'b1;
               tag_q[r]  <= dec_rob_id;
            end else if (commit_reg_id == REG_WIDTH'(r) && busy_q[r] &&
                         tag_q[r] == commit_rob_id) begin
               busy_q[r] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_register_file_rename.sv
// Bench for register_file_rename: directed vector table, hand-written reset sequence and
// randomized traffic against a behavioural register/tag model.
module tb_register_file_rename;

   logic        clk_in = 1'b0;
   logic        rst_n_in = 1'b0;
   logic        rdy_in = 1'b1;
   logic        flush = 1'b0;
   logic [4:0]  dec_rs1 = '0;
   logic [4:0]  dec_rs2 = '0;
   logic        dec_ready_j, dec_ready_k;
   logic [31:0] dec_val_j, dec_val_k;
   logic [3:0]  dec_tag_j, dec_tag_k;
   logic        dec_rename_en = 1'b0;
   logic [4:0]  dec_rd = '0;
   logic [3:0]  dec_rob_id = '0;
   logic [3:0]  rob_query_j, rob_query_k;
   logic        rob_ready_j = 1'b0;
   logic        rob_ready_k = 1'b0;
   logic [31:0] rob_data_j = '0;
   logic [31:0] rob_data_k = '0;
   logic [4:0]  commit_reg_id = '0;
   logic [31:0] commit_data = '0;
   logic [3:0]  commit_rob_id = '0;

   int pass_cnt = 0;
   int total_cnt = 0;

   register_file_rename #(.REG_WIDTH(5), .ROB_WIDTH(4)) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush(flush),
      .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
      .dec_ready_j(dec_ready_j), .dec_val_j(dec_val_j), .dec_tag_j(dec_tag_j),
      .dec_ready_k(dec_ready_k), .dec_val_k(dec_val_k), .dec_tag_k(dec_tag_k),
      .dec_rename_en(dec_rename_en), .dec_rd(dec_rd), .dec_rob_id(dec_rob_id),
      .rob_query_j(rob_query_j), .rob_query_k(rob_query_k),
      .rob_ready_j(rob_ready_j), .rob_ready_k(rob_ready_k),
      .rob_data_j(rob_data_j), .rob_data_k(rob_data_k),
      .commit_reg_id(commit_reg_id), .commit_data(commit_data), .commit_rob_id(commit_rob_id)
   );

   always #5 clk_in = ~clk_in;

   // ---------------- reference model ----------------
   logic [31:0] m_val  [32];
   logic        m_busy [32];
   logic [3:0]  m_tag  [32];

   task automatic model_reset();
      for (int r = 0; r < 32; r++) begin
         m_val[r] = '0; m_busy[r] = 1'b0; m_tag[r] = '0;
      end
   endtask

   // Returns {ready, value, tag} for one operand, following the resolution priority list.
   function automatic logic [36:0] model_read(input logic [4:0] s, input logic rr, input logic [31:0] rd);
      if (s == 0)                                                   return {1'b1, 32'd0, m_tag[s]};
      if (!m_busy[s])                                               return {1'b1, m_val[s], m_tag[s]};
      if (commit_reg_id == s && commit_rob_id == m_tag[s])          return {1'b1, commit_data, m_tag[s]};
      if (rr)                                                       return {1'b1, rd, m_tag[s]};
      return {1'b0, 32'd0, m_tag[s]};
   endfunction

   task automatic model_edge();
      if (!rdy_in) return;
      if (commit_reg_id != 0) begin
         m_val[commit_reg_id] = commit_data;
         if (m_busy[commit_reg_id] && m_tag[commit_reg_id] == commit_rob_id) m_busy[commit_reg_id] = 1'b0;
      end
      if (flush) begin
         for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
      end else if (dec_rename_en && dec_rd != 0) begin
         m_busy[dec_rd] = 1'b1;
         m_tag[dec_rd]  = dec_rob_id;
      end
   endtask

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic check_side(input string tag_s, input logic [36:0] exp, input logic r, input logic [31:0] v,
                             input logic [3:0] t, input logic [3:0] q);
      check({tag_s, " ready"}, 32'(r), 32'(exp[36]));
      check({tag_s, " val"},   v,      exp[35:4]);
      check({tag_s, " tag"},   32'(t), 32'(exp[3:0]));
      check({tag_s, " query"}, 32'(q), 32'(exp[3:0]));
   endtask

   task automatic clk_edge();
      @(posedge clk_in);
      model_edge();
   endtask

   task automatic idle_inputs();
      rdy_in = 1'b1; flush = 1'b0; dec_rename_en = 1'b0; dec_rd = '0; dec_rob_id = '0;
      commit_reg_id = '0; commit_data = '0; commit_rob_id = '0;
      dec_rs1 = '0; dec_rs2 = '0; rob_ready_j = 1'b0; rob_ready_k = 1'b0;
      rob_data_j = '0; rob_data_k = '0;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic rdy; logic fl; logic ren; logic [4:0] rd; logic [3:0] rob;
      logic [4:0] creg; logic [31:0] cdata; logic [3:0] crob;
      logic [4:0] rs1; logic rrj; logic [31:0] rdj;
      logic [4:0] rs2; logic rrk; logic [31:0] rdk;
      logic erj; logic [31:0] evj; logic [3:0] etj;
      logic erk; logic [31:0] evk; logic [3:0] etk;
   } vec_t;

   function automatic vec_t mk(input logic rdy, fl, ren, input logic [4:0] rd, input logic [3:0] rob,
                               input logic [4:0] creg, input logic [31:0] cdata, input logic [3:0] crob,
                               input logic [4:0] rs1, input logic rrj, input logic [31:0] rdj,
                               input logic [4:0] rs2, input logic rrk, input logic [31:0] rdk,
                               input logic erj, input logic [31:0] evj, input logic [3:0] etj,
                               input logic erk, input logic [31:0] evk, input logic [3:0] etk);
      vec_t v;
      v.rdy = rdy; v.fl = fl; v.ren = ren; v.rd = rd; v.rob = rob;
      v.creg = creg; v.cdata = cdata; v.crob = crob;
      v.rs1 = rs1; v.rrj = rrj; v.rdj = rdj; v.rs2 = rs2; v.rrk = rrk; v.rdk = rdk;
      v.erj = erj; v.evj = evj; v.etj = etj; v.erk = erk; v.evk = evk; v.etk = etk;
      return v;
   endfunction

   vec_t vecs [$];
   logic [36:0] exp_q [$];

   initial begin
      logic [36:0] e;
      vec_t v;
      //             rdy fl ren rd rob  creg cdata    crob  rs1 rrj rdj    rs2 rrk rdk    erj evj      etj erk evk      etk
      vecs.push_back(mk(1, 0, 0, 0, 0,  0, 0,        0,    5, 0, 0,      0, 0, 0,       1, 0,        0,  1, 0,        0));
      vecs.push_back(mk(1, 0, 1, 3, 7,  0, 0,        0,    3, 0, 0,      0, 0, 0,       1, 0,        0,  1, 0,        0));
      vecs.push_back(mk(1, 0, 0, 0, 0,  0, 0,        0,    3, 0, 0,      0, 0, 0,       0, 0,        7,  1, 0,        0));
      vecs.push_back(mk(1, 0, 0, 0, 0,  0, 0,        0,    3, 1, 'h55,   0, 0, 0,       1, 'h55,     7,  1, 0,        0));
      vecs.push_back(mk(1, 0, 0, 0, 0,  3, 'hDEAD,   7,    0, 0, 0,      3, 0, 0,       1, 0,        0,  1, 'hDEAD,   7));
      vecs.push_back(mk(1, 0, 0, 0, 0,  0, 0,        0,    3, 1, 'h99,   3, 0, 0,       1, 'hDEAD,   7,  1, 'hDEAD,   7));
      vecs.push_back(mk(1, 0, 1, 4, 2,  0, 0,        0,    0, 0, 0,      0, 0, 0,       1, 0,        0,  1, 0,        0));
      vecs.push_back(mk(1, 0, 1, 4, 5,  0, 0,        0,    4, 0, 0,      0, 0, 0,       0, 0,        2,  1, 0,        0));
      vecs.push_back(mk(1, 0, 0, 0, 0,  4, 'h1234,   2,    4, 0, 0,      4, 0, 0,       0, 0,        5,  0, 0,        5));
      vecs.push_back(mk(1, 0, 0, 0, 0,  0, 0,        0,    4, 1, 'h77,   4, 0, 0,       1, 'h77,     5,  0, 0,        5));
      vecs.push_back(mk(1, 0, 0, 0, 0,  4, 'hBEEF,   5,    4, 0, 0,      0, 0, 0,       1, 'hBEEF,   5,  1, 0,        0));
      vecs.push_back(mk(1, 0, 1, 6, 9,  6, 'hC0DE,   1,    6, 0, 0,      0, 0, 0,       1, 0,        0,  1, 0,        0));
      vecs.push_back(mk(1, 0, 0, 0, 0,  0, 0,        0,    6, 0, 0,      6, 0, 0,       0, 0,        9,  0, 0,        9));
      vecs.push_back(mk(1, 0, 1, 1, 10, 0, 0,        0,    1, 0, 0,      0, 0, 0,       1, 0,        0,  1, 0,        0));
      vecs.push_back(mk(1, 0, 1, 2, 11, 0, 0,        0,    1, 0, 0,      0, 0, 0,       0, 0,        10, 1, 0,        0));
      vecs.push_back(mk(1, 1, 1, 8, 12, 7, 'h7777,   3,    2, 0, 0,      6, 0, 0,       0, 0,        11, 0, 0,        9));
      vecs.push_back(mk(1, 0, 0, 0, 0,  0, 0,        0,    6, 0, 0,      1, 0, 0,       1, 'hC0DE,   9,  1, 0,        10));
      vecs.push_back(mk(1, 0, 0, 0, 0,  0, 0,        0,    8, 0, 0,      2, 0, 0,       1, 0,        0,  1, 0,        11));
      vecs.push_back(mk(1, 0, 1, 0, 3,  0, 'hFFFF,   0,    0, 0, 0,      7, 0, 0,       1, 0,        0,  1, 'h7777,   0));
      vecs.push_back(mk(1, 0, 0, 0, 0,  0, 0,        0,    0, 1, 'h42,   0, 1, 'h43,    1, 0,        0,  1, 0,        0));
      vecs.push_back(mk(0, 0, 1, 5, 4,  3, 'hAAAA,   7,    5, 0, 0,      3, 0, 0,       1, 0,        0,  1, 'hDEAD,   7));
      vecs.push_back(mk(1, 0, 0, 0, 0,  0, 0,        0,    5, 0, 0,      3, 0, 0,       1, 0,        0,  1, 'hDEAD,   7));

      // ---- reset ----
      idle_inputs();
      model_reset();
      dec_rs1 = 5'd5;
      #12;
      check_side("in_reset j", {1'b1, 32'd0, 4'd0}, dec_ready_j, dec_val_j, dec_tag_j, rob_query_j);
      @(negedge clk_in);
      rst_n_in = 1'b1;

      // ---- directed table ----
      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         @(negedge clk_in);
         rdy_in = v.rdy; flush = v.fl; dec_rename_en = v.ren; dec_rd = v.rd; dec_rob_id = v.rob;
         commit_reg_id = v.creg; commit_data = v.cdata; commit_rob_id = v.crob;
         dec_rs1 = v.rs1; rob_ready_j = v.rrj; rob_data_j = v.rdj;
         dec_rs2 = v.rs2; rob_ready_k = v.rrk; rob_data_k = v.rdk;
         #1;
         check_side($sformatf("vec%0d j", i), {v.erj, v.evj, v.etj}, dec_ready_j, dec_val_j, dec_tag_j, rob_query_j);
         check_side($sformatf("vec%0d k", i), {v.erk, v.evk, v.etk}, dec_ready_k, dec_val_k, dec_tag_k, rob_query_k);
         clk_edge();
      end

      // ---- randomized traffic against the model ----
      for (int n = 0; n < 400; n++) begin
         @(negedge clk_in);
         rdy_in        = ($urandom_range(0, 7) != 0);
         flush         = ($urandom_range(0, 24) == 0);
         dec_rename_en = $urandom_range(0, 1);
         dec_rd        = 5'($urandom_range(0, 7));
         dec_rob_id    = 4'($urandom);
         commit_reg_id = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(0, 7));
         commit_data   = $urandom;
         commit_rob_id = ($urandom_range(0, 1) == 1) ? m_tag[commit_reg_id] : 4'($urandom);
         dec_rs1       = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
         dec_rs2       = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
         rob_ready_j   = $urandom_range(0, 1);
         rob_ready_k   = $urandom_range(0, 1);
         rob_data_j    = $urandom;
         rob_data_k    = $urandom;
         exp_q.push_back(model_read(dec_rs1, rob_ready_j, rob_data_j));
         exp_q.push_back(model_read(dec_rs2, rob_ready_k, rob_data_k));
         #1;
         e = exp_q.pop_front();
         check_side($sformatf("rnd%0d j", n), e, dec_ready_j, dec_val_j, dec_tag_j, rob_query_j);
         e = exp_q.pop_front();
         check_side($sformatf("rnd%0d k", n), e, dec_ready_k, dec_val_k, dec_tag_k, rob_query_k);
         clk_edge();
      end

      // ---- asynchronous reset with a busy register ----
      @(negedge clk_in);
      idle_inputs();
      dec_rename_en = 1'b1; dec_rd = 5'd3; dec_rob_id = 4'd6;
      clk_edge();
      @(negedge clk_in);
      idle_inputs();
      dec_rs1 = 5'd3;
      #1;
      check_side("pre_reset j", {1'b0, 32'd0, 4'd6}, dec_ready_j, dec_val_j, dec_tag_j, rob_query_j);
      rst_n_in = 1'b0;
      model_reset();
      #1;
      check_side("async_reset j", {1'b1, 32'd0, 4'd0}, dec_ready_j, dec_val_j, dec_tag_j, rob_query_j);
      @(negedge clk_in);
      rst_n_in = 1'b1;
      #1;
      check_side("post_reset j", model_read(dec_rs1, rob_ready_j, rob_data_j), dec_ready_j, dec_val_j, dec_tag_j, rob_query_j);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
